// File: rtl/transmissao_serial_uc_if.sv
// Handshake bundle between the serial-frame control unit and its datapath.
// master: control unit side; slave: datapath side.
interface transmissao_serial_uc_if;
    logic       envia;
    logic       fim_digito;
    logic       fim_envio;
    logic       render_clr;
    logic       comeca_transmissao;
    logic       conta_digito;
    logic       ocupado;
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    modport master (
        input  envia,
        input  fim_digito,
        input  fim_envio,
        output render_clr,
        output comeca_transmissao,
        output conta_digito,
        output ocupado,
        output pronto,
        output erro,
        output db_estado
    );

    modport slave (
        output envia,
        output fim_digito,
        output fim_envio,
        input  render_clr,
        input  comeca_transmissao,
        input  conta_digito,
        input  ocupado,
        input  pronto,
        input  erro,
        input  db_estado
    );
endinterface

// File: rtl/transmissao_serial_uc.sv
// Control unit for the serial frame datapath: clears the datapath, then for each
// character starts the UART, waits for its done pulse (with timeout) and advances
// the character selector until the frame is complete.
// Optional feature: define TX_AUTO_FRAME_EN to add a free-running period counter
// that requests a frame every AUTO_PERIOD cycles.
module transmissao_serial_uc #(
    parameter int unsigned N_CHARS     = 6,
    parameter int unsigned TIMEOUT     = 20000,
    parameter int unsigned AUTO_PERIOD = 5000000
) (
    input logic                      clock,
    input logic                      reset,
    transmissao_serial_uc_if.master  bus
);

    localparam int unsigned IdxW = $clog2(N_CHARS + 1);
    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        StInicial = 4'd0,
        StLimpa   = 4'd1,
        StPartida = 4'd2,
        StEspera  = 4'd3,
        StConta   = 4'd4,
        StDecide  = 4'd5,
        StFinal   = 4'd6,
        StErro    = 4'd7
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic            pending_q, pending_d;
    logic            req;
    logic            busy;

`ifdef TX_AUTO_FRAME_EN
    localparam int unsigned PerW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

    logic [PerW-1:0] per_q, per_d;
    logic            auto_req;

    // Free-running period counter; the wrap cycle doubles as a frame request.
    always_comb begin
        auto_req = (per_q == PerW'(AUTO_PERIOD - 1));
        per_d    = auto_req ? '0 : per_q + 1'b1;
    end

    // Period counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) per_q <= '0;
        else        per_q <= per_d;
    end

    assign req = bus.envia | auto_req;
`else
    assign req = bus.envia;
`endif

    // State and datapath-tracking registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StInicial;
            idx_q     <= '0;
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_d                = state_q;
        idx_d                  = idx_q;
        timer_d                = timer_q;
        pending_d              = pending_q;
        bus.render_clr         = 1'b0;
        bus.comeca_transmissao = 1'b0;
        bus.conta_digito       = 1'b0;
        bus.pronto             = 1'b0;
        bus.erro               = 1'b0;
        busy                   = 1'b0;

        case (state_q)
            StInicial: begin
                if (req || pending_q) begin
                    state_d   = StLimpa;
                    pending_d = 1'b0;
                end
            end
            StLimpa: begin
                busy           = 1'b1;
                bus.render_clr = 1'b1;
                idx_d          = '0;
                state_d        = StPartida;
            end
            StPartida: begin
                busy                   = 1'b1;
                bus.comeca_transmissao = 1'b1;
                timer_d                = '0;
                state_d                = StEspera;
            end
            StEspera: begin
                busy    = 1'b1;
                timer_d = timer_q + 1'b1;
                // A done pulse on the timeout cycle still counts as success.
                if (bus.fim_digito)                       state_d = StConta;
                else if (timer_q == TmrW'(TIMEOUT - 1))   state_d = StErro;
            end
            StConta: begin
                busy             = 1'b1;
                bus.conta_digito = 1'b1;
                idx_d            = idx_q + 1'b1;
                state_d          = StDecide;
            end
            StDecide: begin
                // Settle cycle: selector mux output is stable before the next start.
                busy = 1'b1;
                if ((idx_q == IdxW'(N_CHARS)) || bus.fim_envio) state_d = StFinal;
                else                                            state_d = StPartida;
            end
            StFinal: begin
                busy       = 1'b1;
                bus.pronto = 1'b1;
                state_d    = StInicial;
            end
            StErro: begin
                bus.erro       = 1'b1;
                bus.render_clr = 1'b1;
                if (req) state_d = StLimpa;
            end
            default: state_d = StInicial;
        endcase

        // One-deep request memory while a frame is in flight.
        if (busy && req) pending_d = 1'b1;
    end

    assign bus.ocupado   = busy;
    assign bus.db_estado = state_q;

endmodule

// File: tb/tb_transmissao_serial_uc.sv
// Bench for transmissao_serial_uc: expected output waveforms are planned from frame
// timing arithmetic (frame start, character count, UART latency) and compared every
// cycle; a UART model answers each start and a selector model tracks the datapath.
module tb_transmissao_serial_uc;

    localparam int NC      = 6;
    localparam int TO      = 50;
    localparam int AP      = 400;
    localparam int DEPTH   = 1024;
    localparam int END_CYC = 940;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    transmissao_serial_uc_if u_if ();

    transmissao_serial_uc #(
        .N_CHARS    (NC),
        .TIMEOUT    (TO),
        .AUTO_PERIOD(AP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (u_if)
    );

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [9:0] exp_vec [DEPTH];
    int         exp_char[DEPTH];
    int         lat = 11;
    logic       uart_on = 1'b1;
    int         fire_at = -1;
    logic       chk_on = 1'b0;
    int         sel = 0;
    int         n_rc = 0, n_st = 0, n_cd = 0;
    int         pr_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output vector implied by a state code: {render_clr, start, conta, ocupado, pronto, erro, code}.
    function automatic logic [9:0] outs_of(input int code);
        logic       rc, st, cd, oc, pr, er;
        logic [3:0] c4;
        c4 = code[3:0];
        rc = (code == 1) || (code == 7);
        st = (code == 2);
        cd = (code == 4);
        oc = (code >= 1) && (code <= 6);
        pr = (code == 6);
        er = (code == 7);
        return {rc, st, cd, oc, pr, er, c4};
    endfunction

    task automatic put(input int c, input int code, input int cut);
        if (c < cut && c < DEPTH) exp_vec[c] = outs_of(code);
    endtask

    // Frame whose clear cycle is s, sending n characters with UART latency l.
    task automatic plan_frame(input int s, input int n, input int l, input int cut,
                              output int f);
        int p;
        put(s, 1, cut);
        for (int k = 0; k < n; k++) begin
            p = s + 1 + k * (l + 3);
            put(p, 2, cut);
            if (p < cut) exp_char[p] = k;
            for (int j = 1; j <= l; j++) put(p + j, 3, cut);
            put(p + l + 1, 4, cut);
            put(p + l + 2, 5, cut);
        end
        f = s + 1 + n * (l + 3);
        put(f, 6, cut);
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {u_if.render_clr, u_if.comeca_transmissao, u_if.conta_digito, u_if.ocupado,
                u_if.pronto, u_if.erro, u_if.db_estado};
    endfunction

    // UART model: done pulse lat cycles after the start cycle.
    always @(posedge clock) begin
        #1;
        u_if.fim_digito = (cyc == fire_at);
    end

    // Cycle compare, monitors and datapath selector model.
    always @(negedge clock) begin
        logic [9:0] act;
        act = dut_vec();
        if (chk_on && cyc < DEPTH) begin
            total++;
            if (act !== exp_vec[cyc]) begin
                bad++;
                $display("FAIL outputs cycle %0d: got %b expected %b", cyc, act, exp_vec[cyc]);
            end
        end
        if (u_if.render_clr) n_rc++;
        if (u_if.conta_digito) n_cd++;
        if (u_if.pronto) pr_q.push_back(cyc);
        if (u_if.comeca_transmissao) begin
            n_st++;
            if (uart_on) fire_at = cyc + lat;
            if (chk_on && cyc < DEPTH) chk("selector at start", sel, exp_char[cyc]);
        end
        if (u_if.render_clr) sel = 0;
        else if (u_if.conta_digito) sel++;
    end

`ifdef TX_AUTO_FRAME_EN
    initial begin
        u_if.envia     = 1'b0;
        u_if.fim_envio = 1'b0;
        at_cycle(2);
        chk("reset db_estado", int'(u_if.db_estado), 0);
        at_cycle(3);
        reset = 1'b1;
        at_cycle(1303);
        chk("auto pronto count", pr_q.size(), 3);
        chk("auto start count", n_st, 3 * NC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`else
    initial begin
        int f;
        for (int i = 0; i < DEPTH; i++) begin
            exp_vec[i]  = '0;
            exp_char[i] = -1;
        end
        plan_frame(11, NC, 11, DEPTH, f);   // single frame
        plan_frame(111, NC, 11, DEPTH, f);  // frame with pending request
        plan_frame(198, NC, 11, DEPTH, f);  // frame launched from pending
        plan_frame(301, 3, 11, DEPTH, f);   // early end via fim_envio
        put(361, 1, DEPTH);                 // timeout frame
        put(362, 2, DEPTH);
        exp_char[362] = 0;
        for (int c = 363; c <= 412; c++) put(c, 3, DEPTH);
        for (int c = 413; c <= 430; c++) put(c, 7, DEPTH);
        plan_frame(431, NC, 11, DEPTH, f);  // recovery frame
        plan_frame(531, NC, 11, 580, f);    // cut by reset
        plan_frame(601, NC, 50, DEPTH, f);  // done pulse on the timeout cycle

        u_if.envia     = 1'b0;
        u_if.fim_envio = 1'b0;
        chk_on         = 1'b1;

        at_cycle(2);
        chk("reset outputs", int'(dut_vec()), 0);
        at_cycle(3);
        reset = 1'b1;

        // Single frame
        at_cycle(10);  u_if.envia = 1'b1;
        at_cycle(11);  u_if.envia = 1'b0;
        at_cycle(98);
        chk("t1 render_clr cycles", n_rc, 1);
        chk("t1 starts", n_st, 6);
        chk("t1 conta pulses", n_cd, 6);
        chk("t1 pronto count", pr_q.size(), 1);
        chk("t1 pronto cycle", pr_q[0], 10 + 6 * 14 + 2);

        // Pending request
        at_cycle(110); u_if.envia = 1'b1;
        at_cycle(111); u_if.envia = 1'b0;
        at_cycle(145); u_if.envia = 1'b1;
        at_cycle(146); u_if.envia = 1'b0;
        at_cycle(290);
        chk("t2 starts", n_st - 6, 12);
        chk("t2 first pronto", pr_q[1], 196);
        chk("t2 second pronto", pr_q[2], 283);

        // Early end
        at_cycle(300); u_if.envia = 1'b1;
        at_cycle(301); u_if.envia = 1'b0;
        at_cycle(343); u_if.fim_envio = 1'b1;
        at_cycle(344); u_if.fim_envio = 1'b0;
        at_cycle(350);
        chk("t4 starts", n_st - 18, 3);
        chk("t4 pronto cycle", pr_q[3], 344);

        // Timeout
        at_cycle(360); u_if.envia = 1'b1; uart_on = 1'b0;
        at_cycle(361); u_if.envia = 1'b0;
        at_cycle(413);
        #2;
        chk("t3 erro", int'(u_if.erro), 1);
        chk("t3 render_clr", int'(u_if.render_clr), 1);
        chk("t3 ocupado", int'(u_if.ocupado), 0);
        chk("t3 db_estado", int'(u_if.db_estado), 7);
        at_cycle(420); uart_on = 1'b1;
        at_cycle(430); u_if.envia = 1'b1;
        at_cycle(431); u_if.envia = 1'b0;
        #2;
        chk("t3 erro cleared", int'(u_if.erro), 0);
        at_cycle(520);
        chk("t3 recovery pronto", pr_q[4], 516);

        // Reset mid-frame
        at_cycle(530); u_if.envia = 1'b1;
        at_cycle(531); u_if.envia = 1'b0;
        at_cycle(580);
        chk("t5 waiting state", int'(u_if.db_estado), 3);
        reset = 1'b0;
        #1;
        chk("t5 async reset outputs", int'(dut_vec()), 0);
        at_cycle(583); reset = 1'b1;
        at_cycle(590);
        chk("t5 no pronto", pr_q.size(), 5);

        // Done pulse coinciding with the timeout cycle
        at_cycle(600); lat = 50; u_if.envia = 1'b1;
        at_cycle(601); u_if.envia = 1'b0;
        at_cycle(END_CYC);
        chk("t6 pronto count", pr_q.size(), 6);
        chk("t6 pronto cycle", pr_q[5], 920);
        chk("t6 erro", int'(u_if.erro), 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`endif

endmodule
